// File: rtl/gpio_bcd_display.sv
// gpio_bcd_display
//   Watches the CPU GPIO output word, converts it to decimal with an iterative
//   shift-add-3 (double-dabble) engine and drives active-low seven-segment
//   digits. A conversion starts automatically whenever the watched word
//   differs from the last captured one, so software needs no handshake.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous reset, active-low
//   value_in  : binary value to display (CPU gpio_out)
//   bcd_out   : last completed conversion, digit 0 in [3:0]
//   hex_out   : segments, digit k in [7k+6:7k], bit6 = g .. bit0 = a, active-low
//   busy      : conversion in progress (state not IDLE)
//   valid     : a conversion has completed since reset
//   overflow  : last result has a nonzero digit beyond the physical display
module gpio_bcd_display #(
    parameter int IN_WIDTH   = 32,
    parameter int BCD_DIGITS = 10,
    parameter int HEX_DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_WIDTH-1:0]       value_in,
    output logic [4*BCD_DIGITS-1:0]   bcd_out,
    output logic [7*HEX_DIGITS-1:0]   hex_out,
    output logic                      busy,
    output logic                      valid,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int ACC_W = 4 * BCD_DIGITS;
    localparam int HEX_W = 7 * HEX_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, next_state;
    logic [IN_WIDTH-1:0] last_val;
    logic [IN_WIDTH-1:0] bin_sr;
    logic [ACC_W-1:0]    bcd_acc;
    logic [CNT_W-1:0]    cnt;
    logic                pending;

    logic                start;
    logic                last_step;
    logic [ACC_W-1:0]    adj;
    logic                ovf_next;
    logic [HEX_W-1:0]    hex_next;
    logic                leading;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // A forced (post-reset) conversion or any change of the watched word.
    assign start     = pending || (value_in != last_val);
    assign last_step = (cnt == CNT_W'(IN_WIDTH - 1));
    assign busy      = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction, result decode and overflow detection.
    always_comb begin
        adj      = bcd_acc;
        ovf_next = 1'b0;
        hex_next = '1;
        leading  = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            // Nibbles never exceed 9 here, so +3 stays within the nibble.
            if (bcd_acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
        for (int i = HEX_DIGITS; i < BCD_DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] != 4'd0) ovf_next = 1'b1;
        end
        // Walk from the top digit down; digits stay blank until the first
        // nonzero one, and digit 0 is always shown.
        for (int k = HEX_DIGITS - 1; k >= 0; k--) begin
            if (bcd_acc[4*k +: 4] != 4'd0) leading = 1'b0;
            if (ovf_next)
                hex_next[7*k +: 7] = SEG_DASH;
            else if (!leading || k == 0)
                hex_next[7*k +: 7] = seg7(bcd_acc[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_val <= '0;
            bin_sr   <= '0;
            bcd_acc  <= '0;
            cnt      <= '0;
            pending  <= 1'b1;
            bcd_out  <= '0;
            hex_out  <= '1;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_val <= value_in;
                        bin_sr   <= value_in;
                        bcd_acc  <= '0;
                        cnt      <= '0;
                        pending  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_acc <= (adj << 1) | ACC_W'(bin_sr[IN_WIDTH-1]);
                    bin_sr  <= bin_sr << 1;
                    cnt     <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd_out  <= bcd_acc;
                    overflow <= ovf_next;
                    valid    <= 1'b1;
                    hex_out  <= hex_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bcd_display.sv
module tb_gpio_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value_in = '0;
    logic [39:0] bcd_out;
    logic [55:0] hex_out;
    logic        busy, valid, overflow;

    int total = 0;
    int bad   = 0;

    gpio_bcd_display dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .hex_out  (hex_out),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic on the value.
    function automatic logic [39:0] ref_bcd(input longint unsigned v);
        logic [39:0] r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v);
        return v > 64'd99999999;
    endfunction

    function automatic logic [55:0] ref_hex(input longint unsigned v);
        logic [55:0]     r = '1;
        int              ndig = 1;
        longint unsigned t = v / 10;
        if (ref_ovf(v)) begin
            for (int k = 0; k < 8; k++) r[7*k +: 7] = 7'b0111111;
            return r;
        end
        while (t != 0) begin
            ndig++;
            t = t / 10;
        end
        t = v;
        for (int k = 0; k < ndig; k++) begin
            r[7*k +: 7] = seg_tab[t % 10];
            t = t / 10;
        end
        return r;
    endfunction

    // Counts rising edges, starting from the next one, until busy is seen low.
    task automatic count_until_idle(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 200);
    endtask

    task automatic check_result(input string tag, input longint unsigned v);
        check({tag, ".bcd"}, 64'(bcd_out), 64'(ref_bcd(v)));
        check({tag, ".hex"}, 64'(hex_out), 64'(ref_hex(v)));
        check({tag, ".ovf"}, 64'(overflow), 64'(ref_ovf(v)));
        check({tag, ".valid"}, 64'(valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".bcd"}, 64'(bcd_out), 64'd0);
        check({tag, ".hex"}, 64'(hex_out), 64'h00FF_FFFF_FFFF_FFFF);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".valid"}, 64'(valid), 64'd0);
        check({tag, ".ovf"}, 64'(overflow), 64'd0);
    endtask

    // Apply a new value while idle and check latency and result.
    task automatic convert(input string tag, input logic [31:0] v);
        int n;
        @(negedge clk);
        value_in = v;
        count_until_idle(n);
        check({tag, ".edges"}, 64'(n), 64'd34);
        check_result(tag, longint'(v));
    endtask

    initial begin
        int          n;
        int          idle_busy;
        logic [31:0] v;

        // Reset state, value 0 held.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        count_until_idle(n);
        check("zero.edges", 64'(n), 64'd34);
        check_result("zero", 0);

        // Steady value and no re-trigger while unchanged.
        convert("d12345678", 32'd12345678);
        idle_busy = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy) idle_busy++;
        end
        check("hold.busy", 64'(idle_busy), 64'd0);
        check_result("hold", 12345678);

        convert("max", 32'hFFFF_FFFF);
        check("max.bcd_lit", 64'(bcd_out), 64'h42_9496_7295);
        convert("d99999999", 32'd99999999);
        convert("d100000000", 32'd100000000);
        check("d100000000.bcd_lit", 64'(bcd_out), 64'h01_0000_0000);

        // Change during a conversion: 7 shown first, then 99 after recapture.
        @(negedge clk);
        value_in = 32'd7;
        repeat (5) @(posedge clk);
        @(negedge clk);
        value_in = 32'd99;
        count_until_idle(n);
        check("chg.first_edges", 64'(n), 64'd29);
        check_result("chg7", 7);
        count_until_idle(n);
        check("chg.second_edges", 64'(n), 64'd34);
        check_result("chg99", 99);

        // Reset in the middle of a conversion.
        @(negedge clk);
        value_in = 32'd100;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        count_until_idle(n);
        check("midrst.edges", 64'(n), 64'd34);
        check_result("after_rst", 100);

        // Randomized values of mixed magnitude.
        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99999);
                default: v = $urandom_range(90000000, 110000000);
            endcase
            if (v == value_in) v = v ^ 32'd1;
            convert($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
